// File: rtl/vga_pkg.sv
// Shared timing defaults and helpers for the VGA raster pipeline.
// Default timing is 640x480@60 with a 25.175 MHz pixel rate.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } raster_flags_t;

  // Widen a w-bit colour to 4 bits by repeating its MSBs into the low bits,
  // so that full scale stays full scale.
  function automatic logic [3:0] expand4(input logic [3:0] in, input int unsigned w);
    logic [3:0] out;
    out = in;
    case (w)
      1:       out = {4{in[0]}};
      2:       out = {in[1:0], in[1:0]};
      3:       out = {in[2:0], in[2]};
      default: out = in;
    endcase
    return out;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-pulse decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL  = DEF_H_TOTAL,
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [9:0] count,
  output logic       wrap,
  output logic       active,
  output logic       sync_act
);

  localparam logic [10:0] LAST    = 11'(TOTAL - 1);
  localparam logic [10:0] ACT_END = 11'(ACTIVE);
  localparam logic [10:0] SYNC_LO = 11'(ACTIVE + FP);
  localparam logic [10:0] SYNC_HI = 11'(ACTIVE + FP + SYNC);

  logic [9:0]  count_q, count_d;
  logic [10:0] count_x;

  assign count_x = {1'b0, count_q};

  // wrap is qualified by inc so it can directly advance the next axis
  assign wrap     = inc && (count_x == LAST);
  assign active   = count_x < ACT_END;
  assign sync_act = (count_x >= SYNC_LO) && (count_x < SYNC_HI);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA raster timing generator: lookahead coordinates to the pixel source, sync/blank
// delayed to match the source read latency, registered and polarity-adjusted pins.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned HSYNC_POL = 0,
  parameter int unsigned VSYNC_POL = 0,
  parameter int unsigned PIXEL_LAT = 1,
  parameter int unsigned R_W       = 3,
  parameter int unsigned G_W       = 3,
  parameter int unsigned B_W       = 2
) (
  input  logic           vgaclk,
  input  logic           rst,
  input  logic           pix_ce,
  input  logic [R_W-1:0] input_red,
  input  logic [G_W-1:0] input_green,
  input  logic [B_W-1:0] input_blue,
  output logic [9:0]     hc_out,
  output logic [9:0]     vc_out,
  output logic           frame_start,
  output logic           line_start,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [3:0]     red,
  output logic [3:0]     green,
  output logic [3:0]     blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic        HS_IDLE = (HSYNC_POL == 0);
  localparam logic        VS_IDLE = (VSYNC_POL == 0);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_pipe: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (PIXEL_LAT > 4) begin : g_bad_lat
    $error("vga_timing_pipe: PIXEL_LAT must be 0..4");
  end
  if (R_W < 1 || R_W > 4 || G_W < 1 || G_W > 4 || B_W < 1 || B_W > 4) begin : g_bad_width
    $error("vga_timing_pipe: colour widths must be 1..4");
  end

  logic          h_wrap, h_act, h_sync;
  logic          v_wrap_unused, v_act, v_sync;
  logic [9:0]    hc, vc;
  raster_flags_t s0, dly;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC)
  ) u_h (
    .clk     (vgaclk),
    .rst     (rst),
    .inc     (pix_ce),
    .count   (hc),
    .wrap    (h_wrap),
    .active  (h_act),
    .sync_act(h_sync)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC)
  ) u_v (
    .clk     (vgaclk),
    .rst     (rst),
    .inc     (h_wrap),
    .count   (vc),
    .wrap    (v_wrap_unused),
    .active  (v_act),
    .sync_act(v_sync)
  );

  assign s0          = '{act: h_act & v_act, hs: h_sync, vs: v_sync};
  assign hc_out      = hc;
  assign vc_out      = vc;
  assign line_start  = pix_ce & ~rst & (hc == '0);
  assign frame_start = pix_ce & ~rst & (hc == '0) & (vc == '0);

  // Flags wait here for as many enables as the source needs to return colour.
  if (PIXEL_LAT == 0) begin : g_no_dly
    assign dly = s0;
  end else begin : g_dly
    raster_flags_t pipe_q [PIXEL_LAT];

    always_ff @(posedge vgaclk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < PIXEL_LAT; i++) begin
          pipe_q[i] <= '0;
        end
      end else if (pix_ce) begin
        pipe_q[0] <= s0;
        for (int unsigned i = 1; i < PIXEL_LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign dly = pipe_q[PIXEL_LAT-1];
  end

  logic       de_q, de_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic [3:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  always_comb begin
    de_d    = dly.act;
    hsync_d = dly.hs ^ HS_IDLE;
    vsync_d = dly.vs ^ VS_IDLE;
    red_d   = dly.act ? expand4(4'(input_red), R_W)   : '0;
    green_d = dly.act ? expand4(4'(input_green), G_W) : '0;
    blue_d  = dly.act ? expand4(4'(input_blue), B_W)  : '0;
  end

  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      de_q    <= 1'b0;
      hsync_q <= HS_IDLE;
      vsync_q <= VS_IDLE;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pix_ce) begin
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: a default-timing instance and a small-raster instance
// (latency 2, positive syncs, 1/4/3-bit colour) checked against an enable-count model.
module tb_vga_timing_pipe;

  typedef struct {
    int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
    bit          hpol, vpol;
  } cfg_t;

  cfg_t cfg_a = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, lat:1, hpol:0, vpol:0};
  cfg_t cfg_b = '{ha:8, hfp:2, hsw:3, hbp:2, va:6, vfp:2, vsw:2, vbp:3, lat:2, hpol:1, vpol:1};

  localparam int unsigned HT_B  = 15;
  localparam int unsigned LAT_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, ce_a = 1'b1, ce_b = 1'b1;

  logic [9:0] hc_a, vc_a, hc_b, vc_b;
  logic       fs_a, ls_a, hs_a, vs_a, de_a, fs_b, ls_b, hs_b, vs_b, de_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [0:0] in_r_b;
  logic [3:0] in_g_b;
  logic [2:0] in_b_b;
  logic [31:0] cb;

  int unsigned n_a = 0, n_b = 0;
  int vectors = 0, miscompares = 0;

  vga_timing_pipe u_a (
    .vgaclk(clk), .rst(rst_a), .pix_ce(ce_a),
    .input_red(3'b101), .input_green(3'b011), .input_blue(2'b10),
    .hc_out(hc_a), .vc_out(vc_a), .frame_start(fs_a), .line_start(ls_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .red(r_a), .green(g_a), .blue(b_a)
  );

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1), .VSYNC_POL(1), .PIXEL_LAT(2),
    .R_W(1), .G_W(4), .B_W(3)
  ) u_b (
    .vgaclk(clk), .rst(rst_b), .pix_ce(ce_b),
    .input_red(in_r_b), .input_green(in_g_b), .input_blue(in_b_b),
    .hc_out(hc_b), .vc_out(vc_b), .frame_start(fs_b), .line_start(ls_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .red(r_b), .green(g_b), .blue(b_b)
  );

  // Enables accepted since reset: the only state the model needs.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) n_a <= 0;
    else if (ce_a) n_a <= n_a + 1;
  end
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) n_b <= 0;
    else if (ce_b) n_b <= n_b + 1;
  end

  // Source B returns colour derived from the column it was asked for LAT_B enables ago.
  always_comb begin
    cb = '0;
    if (n_b >= LAT_B) cb = (n_b - LAT_B) % HT_B;
  end
  assign in_r_b = cb[0:0];
  assign in_g_b = cb[3:0];
  assign in_b_b = cb[2:0];

  function automatic logic [3:0] rep4(input int unsigned v, input int unsigned w);
    logic [3:0] r;
    for (int unsigned j = 0; j < 4; j++) r[3-j] = 1'((v >> (w - 1 - (j % w))) & 1);
    return r;
  endfunction

  // Pin state after n enables: shows pixel n-lat-1, or idle before that exists.
  function automatic void model_pins(input cfg_t c, input int unsigned n,
                                     output bit de, output bit hs, output bit vs,
                                     output int unsigned h);
    int unsigned ht, vt, p, v;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    de = 0; hs = !c.hpol; vs = !c.vpol; h = 0;
    if (n >= c.lat + 1) begin
      p  = n - c.lat - 1;
      h  = p % ht;
      v  = (p / ht) % vt;
      de = (h < c.ha) && (v < c.va);
      hs = ((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw)) ? c.hpol : !c.hpol;
      vs = ((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw)) ? c.vpol : !c.vpol;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit          e_de, e_hs, e_vs;
    int unsigned h, ht, vt;
    logic [3:0]  er, eg, eb;

    // Instance A: default timing, constant colour.
    ht = 800; vt = 525;
    model_pins(cfg_a, n_a, e_de, e_hs, e_vs, h);
    chk("a_hc", 32'(hc_a), n_a % ht);
    chk("a_vc", 32'(vc_a), (n_a / ht) % vt);
    chk("a_ls", 32'(ls_a), 32'(ce_a && !rst_a && (n_a % ht == 0)));
    chk("a_fs", 32'(fs_a), 32'(ce_a && !rst_a && (n_a % (ht * vt) == 0)));
    chk("a_de", 32'(de_a), 32'(e_de));
    chk("a_hsync", 32'(hs_a), 32'(e_hs));
    chk("a_vsync", 32'(vs_a), 32'(e_vs));
    chk("a_rgb", {20'd0, r_a, g_a, b_a}, e_de ? 32'h0B6A : 32'h0);

    // Instance B: small raster, colour tracks the column.
    ht = 15; vt = 13;
    model_pins(cfg_b, n_b, e_de, e_hs, e_vs, h);
    er = e_de ? rep4(h & 1, 1)  : 4'h0;
    eg = e_de ? rep4(h & 15, 4) : 4'h0;
    eb = e_de ? rep4(h & 7, 3)  : 4'h0;
    chk("b_hc", 32'(hc_b), n_b % ht);
    chk("b_vc", 32'(vc_b), (n_b / ht) % vt);
    chk("b_ls", 32'(ls_b), 32'(ce_b && !rst_b && (n_b % ht == 0)));
    chk("b_fs", 32'(fs_b), 32'(ce_b && !rst_b && (n_b % (ht * vt) == 0)));
    chk("b_de", 32'(de_b), 32'(e_de));
    chk("b_hsync", 32'(hs_b), 32'(e_hs));
    chk("b_vsync", 32'(vs_b), 32'(e_vs));
    chk("b_rgb", {20'd0, r_b, g_b, b_b}, {20'd0, er, eg, eb});

    // Hand-derived anchor points.
    if (!rst_a && n_a == 657) chk("a_lit_hs_before", 32'(hs_a), 1);
    if (!rst_a && n_a == 658) chk("a_lit_hs_first", 32'(hs_a), 0);
    if (!rst_a && n_a == 753) chk("a_lit_hs_last", 32'(hs_a), 0);
    if (!rst_a && n_a == 754) chk("a_lit_hs_after", 32'(hs_a), 1);
    if (!rst_a && n_a == 641) chk("a_lit_px639", {27'd0, de_a, r_a}, 32'h1B);
    if (!rst_a && n_a == 642) chk("a_lit_px640", {20'd0, de_a, r_a, g_a, b_a[2:0]}, 32'h0);
    if (!rst_a && n_a == 800) chk("a_lit_line1", {12'd0, vc_a, hc_a}, 32'h00400);
    if (!rst_a && ce_a && n_a == 0) chk("a_lit_fs_after_rst", 32'(fs_a), 1);
    if (rst_a) chk("a_lit_rst", {19'd0, hc_a, fs_a, de_a, hs_a}, 32'h1);
    if (rst_b) chk("b_lit_rst", {20'd0, hs_b, vs_b, de_b, r_b, g_b, b_b[0]}, 32'h0);
    if (!rst_b && n_b == 8) chk("b_lit_px5", {20'd0, r_b, g_b, b_b}, 32'hF5B);
    if (!rst_b && n_b == 122) chk("b_lit_vs_before", 32'(vs_b), 0);
    if (!rst_b && n_b == 123) chk("b_lit_vs_first", 32'(vs_b), 1);
    if (!rst_b && n_b == 194) chk("b_lit_last", {12'd0, vc_b, hc_b}, {12'd0, 10'd12, 10'd14});
    if (!rst_b && n_b == 195) chk("b_lit_wrap", {12'd0, vc_b, hc_b}, 32'h0);
  end

  initial begin
    int unsigned a_rst_cnt;
    bit          a_rst_done;
    a_rst_cnt  = 0;
    a_rst_done = 0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int unsigned cyc = 0; cyc < 5200; cyc++) begin
      @(posedge clk);
      #2;
      if (cyc == 3) begin
        rst_a = 1'b0;
        rst_b = 1'b0;
      end
      ce_b = ($urandom_range(0, 3) != 0);
      if (cyc == 700) rst_b = 1'b1;
      if (cyc == 702) rst_b = 1'b0;
      if (cyc >= 1800 && cyc < 3600) ce_a = cyc[0];
      else ce_a = 1'b1;
      if (cyc >= 3600) begin
        if (a_rst_cnt > 0) begin
          a_rst_cnt--;
          if (a_rst_cnt == 0) rst_a = 1'b0;
        end else if (!a_rst_done && (n_a % 800) == 300) begin
          rst_a      = 1'b1;
          a_rst_cnt  = 3;
          a_rst_done = 1;
        end
      end
    end
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
